padovan_seq_ctrl: RTL and testbench

//  Parametrised control FSM for the Padovan register-file/ALU datapath.
//  - Sequences decoder selects (A/B read, C write) and ALU op to walk the series up and/or down by a programmable step count.
//  - Start/busy/done handshake, mode select and stall make it usable under a top-level controller instead of free-running from reset.

---
 rtl/padovan_seq_ctrl_if.sv | 30 +++
 rtl/padovan_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_padovan_seq_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/padovan_seq_ctrl_if.sv
// Handshake and select bus between the Padovan sequencer and its controller.
// The controller side (master) drives start/mode/count/stall; the sequencer
// side (slave) drives the decoder/ALU selects and status.
interface padovan_seq_ctrl_if #(
    parameter int SELECTIONALU  = 3,
    parameter int SELECTIONDECO = 3,
    parameter int CNTW          = 8
);
    logic                     iStart;
    logic [1:0]               iMode;
    logic [CNTW-1:0]          iCount;
    logic                     iStall;
    logic [SELECTIONDECO-1:0] sSelDecoA;
    logic [SELECTIONDECO-1:0] sSelDecoB;
    logic [SELECTIONDECO-1:0] sSelDecoC;
    logic [SELECTIONALU-1:0]  sSelAlu;
    logic                     oBusy;
    logic                     oDone;
    logic [CNTW-1:0]          oStep;

    modport master (
        output iStart, iMode, iCount, iStall,
        input  sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu, oBusy, oDone, oStep
    );

    modport slave (
        input  iStart, iMode, iCount, iStall,
        output sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu, oBusy, oDone, oStep
    );
endinterface

// File: rtl/padovan_seq_ctrl.sv
// Control FSM for the Padovan register-file/ALU datapath. Walks the window
// R0..R3 = P(k)..P(k+3) up and/or down by a latched step count, with a
// start/busy/done handshake and a stall that freezes state and blocks writes.
module padovan_seq_ctrl #(
    parameter int SELECTIONALU  = 3,
    parameter int SELECTIONDECO = 3,
    parameter int CNTW          = 8
) (
    input  logic                clk,
    input  logic                lowRst,
    padovan_seq_ctrl_if.slave   bus
);
    localparam int DW = SELECTIONDECO;
    localparam int AW = SELECTIONALU;

    localparam logic [DW-1:0] NOP_C    = '1;
    localparam logic [DW-1:0] UNUSED_B = '1;
    localparam logic [AW-1:0] ALU_PASS = AW'(0);
    localparam logic [AW-1:0] ALU_SUB  = AW'(1);
    localparam logic [AW-1:0] ALU_ADD  = AW'(2);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] INIT0  = 4'd1;
    localparam logic [3:0] INIT1  = 4'd2;
    localparam logic [3:0] INIT2  = 4'd3;
    localparam logic [3:0] INIT3  = 4'd4;
    localparam logic [3:0] UP_SH0 = 4'd5;
    localparam logic [3:0] UP_SH1 = 4'd6;
    localparam logic [3:0] UP_SH2 = 4'd7;
    localparam logic [3:0] UP_ADD = 4'd8;
    localparam logic [3:0] DN_SUB = 4'd9;
    localparam logic [3:0] DN_SH3 = 4'd10;
    localparam logic [3:0] DN_SH2 = 4'd11;
    localparam logic [3:0] DN_SH1 = 4'd12;
    localparam logic [3:0] DN_SH0 = 4'd13;
    localparam logic [3:0] DONE   = 4'd14;

    logic [3:0]      state, nxt;
    logic [CNTW-1:0] step, nstep, inc;
    logic [1:0]      mode_q;
    logic [CNTW-1:0] n_q;
    logic            active;

    logic [DW-1:0]   a, b, c;
    logic [AW-1:0]   alu;

    assign inc    = step + CNTW'(1);
    assign active = (state != IDLE) && (state != DONE);

    // Successor of each sequencing state, including the step-count phase ends
    always_comb begin
        nxt   = state;
        nstep = step;
        case (state)
            INIT0:  nxt = INIT1;
            INIT1:  nxt = INIT2;
            INIT2:  nxt = INIT3;
            INIT3:  nxt = (n_q == '0) ? DONE : UP_SH0;
            UP_SH0: nxt = UP_SH1;
            UP_SH1: nxt = UP_SH2;
            UP_SH2: nxt = UP_ADD;
            UP_ADD: begin
                nstep = inc;
                if (inc != n_q) begin
                    nxt = UP_SH0;
                end else if (mode_q == 2'b10) begin
                    // combined mode: UP phase done, count the DOWN phase afresh
                    nstep = '0;
                    nxt   = DN_SUB;
                end else begin
                    nxt = DONE;
                end
            end
            DN_SUB: nxt = DN_SH3;
            DN_SH3: nxt = DN_SH2;
            DN_SH2: nxt = DN_SH1;
            DN_SH1: nxt = DN_SH0;
            DN_SH0: begin
                nstep = inc;
                nxt   = (inc == n_q) ? DONE : DN_SUB;
            end
            default: nxt = state;
        endcase
    end

    // State, step counter and latched job parameters
    always_ff @(posedge clk) begin
        if (!lowRst) begin
            state  <= IDLE;
            step   <= '0;
            mode_q <= '0;
            n_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        mode_q <= bus.iMode;
                        n_q    <= bus.iCount;
                        step   <= '0;
                        if (bus.iMode == 2'b01)
                            state <= (bus.iCount == '0) ? DONE : DN_SUB;
                        else
                            state <= INIT0;
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    if (!bus.iStall) begin
                        state <= nxt;
                        step  <= nstep;
                    end
                end
            endcase
        end
    end

    // Moore decode of selects per state
    always_comb begin
        a   = '0;
        b   = UNUSED_B;
        c   = NOP_C;
        alu = ALU_PASS;
        case (state)
            INIT0:  begin a = DW'(6); c = DW'(0); end
            INIT1:  begin a = DW'(6); c = DW'(1); end
            INIT2:  begin a = DW'(6); c = DW'(2); end
            INIT3:  begin a = DW'(0); b = DW'(1); c = DW'(3); alu = ALU_ADD; end
            UP_SH0: begin a = DW'(1); c = DW'(0); end
            UP_SH1: begin a = DW'(2); c = DW'(1); end
            UP_SH2: begin a = DW'(3); c = DW'(2); end
            UP_ADD: begin a = DW'(0); b = DW'(1); c = DW'(3); alu = ALU_ADD; end
            DN_SUB: begin a = DW'(3); b = DW'(1); c = DW'(4); alu = ALU_SUB; end
            DN_SH3: begin a = DW'(2); c = DW'(3); end
            DN_SH2: begin a = DW'(1); c = DW'(2); end
            DN_SH1: begin a = DW'(0); c = DW'(1); end
            DN_SH0: begin a = DW'(4); c = DW'(0); end
            default: begin a = '0; b = '0; end
        endcase
    end

    // A stalled cycle keeps its read selects but must not write
    assign bus.sSelDecoA = a;
    assign bus.sSelDecoB = b;
    assign bus.sSelDecoC = (active && bus.iStall) ? NOP_C : c;
    assign bus.sSelAlu   = alu;
    assign bus.oBusy     = active;
    assign bus.oDone     = (state == DONE);
    assign bus.oStep     = step;
endmodule

// File: tb/tb_padovan_seq_ctrl.sv
// Directed bench for padovan_seq_ctrl: a table of jobs with hand-computed
// done cycles and final register windows, a small register-file model fed by
// the DUT selects, plus hand sequences for reset abort and the select trace.
module tb_padovan_seq_ctrl;
    logic clk = 1'b0;
    logic lowRst;

    padovan_seq_ctrl_if #(.SELECTIONALU(3), .SELECTIONDECO(3), .CNTW(8)) bus ();

    padovan_seq_ctrl #(.SELECTIONALU(3), .SELECTIONDECO(3), .CNTW(8)) dut (
        .clk    (clk),
        .lowRst (lowRst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         n;
        int         scyc;   // first stalled cycle
        int         slen;   // stall length (0 = none)
        bit         pulse;  // extra iStart in cycles 3 and 17
        int         done;   // cycle in which oDone is expected
        int         w0, w1, w2, w3;
    } run_t;

    int total = 0;
    int bad   = 0;
    int regs [0:7];
    logic [11:0] cap [0:15];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int pad(input int k);
        int p0 = 1, p1 = 1, p2 = 1, t;
        for (int i = 0; i < k; i++) begin
            t = p1 + p0; p0 = p1; p1 = p2; p2 = t;
        end
        return p0;
    endfunction

    // Apply the write the current selects will perform at the next edge
    task automatic model_write();
        int av, bv, r;
        av = regs[bus.sSelDecoA];
        bv = regs[bus.sSelDecoB];
        case (bus.sSelAlu)
            3'd1:    r = av - bv;
            3'd2:    r = av + bv;
            default: r = av;
        endcase
        if (bus.sSelDecoC != 3'd7) regs[bus.sSelDecoC] = r;
    endtask

    task automatic run(input run_t r, input string tag);
        int cyc, done_cyc, step_at_done;
        bit stalled;
        @(negedge clk);
        bus.iStart = 1'b1; bus.iMode = r.mode; bus.iCount = 8'(r.n);
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        cyc = 1; done_cyc = 0; step_at_done = -1;
        while (done_cyc == 0 && cyc < 200) begin
            stalled = (r.slen != 0) && (cyc >= r.scyc) && (cyc < r.scyc + r.slen);
            bus.iStall = stalled;
            if (r.pulse && (cyc == 3 || cyc == 17)) begin
                bus.iStart = 1'b1; bus.iMode = 2'b01; bus.iCount = 8'd5;
            end else begin
                bus.iStart = 1'b0;
            end
            @(negedge clk);
            if (cyc <= 15) cap[cyc] = {bus.sSelDecoA, bus.sSelDecoB, bus.sSelDecoC, bus.sSelAlu};
            model_write();
            if (stalled) begin
                chk({tag, " stall C"}, bus.sSelDecoC, 7);
                chk({tag, " stall A held"}, bus.sSelDecoA, 2);
            end
            if (r.slen == 0 && r.mode != 2'b01 && r.mode != 2'b10 && cyc >= 5 && cyc < r.done) begin
                chk({tag, " oStep"}, bus.oStep, (cyc - 5) / 4);
                if ((cyc - 5) % 4 == 3) chk({tag, " R3 after UP"}, regs[3], pad(4 + (cyc - 5) / 4));
            end
            if (bus.oDone) begin
                done_cyc = cyc;
                step_at_done = bus.oStep;
                chk({tag, " busy in DONE"}, bus.oBusy, 0);
            end else begin
                chk({tag, " busy"}, bus.oBusy, 1);
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.iStall = 1'b0; bus.iStart = 1'b0;
        chk({tag, " done cycle"}, done_cyc, r.done);
        chk({tag, " oStep at DONE"}, step_at_done, r.n);
        chk({tag, " R0"}, regs[0], r.w0);
        chk({tag, " R1"}, regs[1], r.w1);
        chk({tag, " R2"}, regs[2], r.w2);
        chk({tag, " R3"}, regs[3], r.w3);
        // Cycle after DONE must be IDLE, and a start ignored in DONE stays ignored
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " idle busy"}, bus.oBusy, 0);
        chk({tag, " idle done"}, bus.oDone, 0);
        chk({tag, " idle C"}, bus.sSelDecoC, 7);
        if (r.pulse) begin
            @(negedge clk);
            chk({tag, " still idle"}, bus.oBusy, 0);
        end
    endtask

    run_t runs [0:7];
    logic [11:0] sel_exp [1:14];

    initial begin
        // mode, N, stall cycle/len, pulse, done cycle, final window
        runs[0] = '{2'b00, 3, 0, 0, 1'b1, 17, 2, 2, 3, 4};
        runs[1] = '{2'b10, 2, 0, 0, 1'b0, 23, 1, 1, 1, 2};
        runs[2] = '{2'b11, 1, 0, 0, 1'b0,  9, 1, 1, 2, 2};
        runs[3] = '{2'b01, 1, 0, 0, 1'b0,  6, 1, 1, 1, 2};
        runs[4] = '{2'b01, 0, 0, 0, 1'b0,  1, 1, 1, 1, 2};
        runs[5] = '{2'b00, 0, 0, 0, 1'b0,  5, 1, 1, 1, 2};
        runs[6] = '{2'b00, 3, 6, 3, 1'b0, 20, 2, 2, 3, 4};
        runs[7] = '{2'b10, 1, 0, 0, 1'b0, 14, 1, 1, 1, 2};
        // {A,B,C,ALU} as octal digits for mode 10, N=1
        sel_exp[1]  = 12'o6700; sel_exp[2]  = 12'o6710; sel_exp[3]  = 12'o6720;
        sel_exp[4]  = 12'o0132; sel_exp[5]  = 12'o1700; sel_exp[6]  = 12'o2710;
        sel_exp[7]  = 12'o3720; sel_exp[8]  = 12'o0132; sel_exp[9]  = 12'o3141;
        sel_exp[10] = 12'o2730; sel_exp[11] = 12'o1720; sel_exp[12] = 12'o0710;
        sel_exp[13] = 12'o4700; sel_exp[14] = 12'o0070;

        for (int i = 0; i < 8; i++) regs[i] = 0;
        regs[6] = 1;
        lowRst = 1'b0;
        bus.iStart = 1'b0; bus.iMode = 2'b00; bus.iCount = 8'd0; bus.iStall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", bus.oBusy, 0);
        chk("reset done", bus.oDone, 0);
        chk("reset C", bus.sSelDecoC, 7);
        chk("reset step", bus.oStep, 0);
        @(posedge clk); #1;
        lowRst = 1'b1;

        for (int i = 0; i < 8; i++) run(runs[i], $sformatf("run%0d", i));

        for (int i = 1; i <= 14; i++) chk($sformatf("sel trace c%0d", i), cap[i], sel_exp[i]);

        // Reset abort mid-run: two low edges return to IDLE with nothing written
        @(negedge clk);
        bus.iStart = 1'b1; bus.iMode = 2'b00; bus.iCount = 8'd3;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        repeat (6) @(posedge clk);
        #1 lowRst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort busy", bus.oBusy, 0);
        chk("abort done", bus.oDone, 0);
        chk("abort C", bus.sSelDecoC, 7);
        chk("abort ALU", bus.sSelAlu, 0);
        chk("abort step", bus.oStep, 0);
        @(posedge clk); #1 lowRst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("post abort idle", bus.oBusy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
